synth_cfg_writer: RTL and testbench

Host-side writer for the synth voice configuration port. Accepts 15-bit configuration words over a valid/ready handshake and serialises each into the byte-wide write strobes the voice expects: the high part via enable bit 1, then the low byte via enable bit 0. A shadow copy of the last word sent suppresses redundant writes. Sits between the control source (sequencer or pin decoder) and the voice's `uio_in`/`ui_in` configuration inputs.

---
 rtl/synth_cfg_if.sv | 20 ++
 rtl/synth_cfg_writer.sv | 142 ++++++++++++++
 tb/tb_synth_cfg_writer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/synth_cfg_if.sv
// Handshake and config-byte bundle between a control source and synth_cfg_writer.
// The master drives words in; the slave (the writer) drives ready, status and the voice strobes.
interface synth_cfg_if;
  logic [14:0] word_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  cfg_out;
  logic [7:0]  cfg_en;
  logic        busy;

  modport master (
    output word_in, in_valid,
    input  in_ready, cfg_out, cfg_en, busy
  );

  modport slave (
    input  word_in, in_valid,
    output in_ready, cfg_out, cfg_en, busy
  );
endinterface

// File: rtl/synth_cfg_writer.sv
// Serialises 15-bit voice config words into HI/LO byte writes on the voice config port,
// skipping bytes that a shadow of the last accepted word shows would not change anything.
module synth_cfg_writer #(
  parameter int unsigned HOLD_CYCLES    = 1,
  parameter int unsigned GAP_CYCLES     = 1,
  parameter bit          SKIP_UNCHANGED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  synth_cfg_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HI,
    S_GAP,
    S_LO
  } state_t;

  localparam logic [14:0] SHADOW_RESET = 15'h0638;
  localparam logic [7:0]  HOLD_LOAD    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]  GAP_LOAD     = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
  localparam bit          HAS_GAP      = (GAP_CYCLES != 0);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [14:0] shadow_q, shadow_d;
  logic        lo_pend_q, lo_pend_d;
  logic [7:0]  cfg_out_q, cfg_out_d;
  logic [1:0]  cfg_en_q, cfg_en_d;

  logic in_ready;
  logic accept;
  logic hi_need;
  logic lo_need;

  assign in_ready = (state_q == S_IDLE) && rst_n;
  assign accept   = bus.in_valid && in_ready;

  // Bit 7 travels in the HI byte, so the LO comparison only looks at bits 6:0.
  assign hi_need = !SKIP_UNCHANGED || (bus.word_in[14:7] != shadow_q[14:7]);
  assign lo_need = !SKIP_UNCHANGED || (bus.word_in[6:0]  != shadow_q[6:0]);

  // NOTE: every always_comb target is given its hold value first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    lo_pend_d = lo_pend_q;
    cfg_out_d = cfg_out_q;
    cfg_en_d  = cfg_en_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          shadow_d  = bus.word_in;
          lo_pend_d = lo_need;
          if (hi_need) begin
            state_d   = S_HI;
            cfg_out_d = bus.word_in[14:7];
            cfg_en_d  = 2'b10;
            cnt_d     = HOLD_LOAD;
          end else if (lo_need) begin
            state_d   = S_LO;
            cfg_out_d = bus.word_in[7:0];
            cfg_en_d  = 2'b01;
            cnt_d     = HOLD_LOAD;
          end
        end
      end

      S_HI: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!lo_pend_q) begin
          state_d  = S_IDLE;
          cfg_en_d = 2'b00;
        end else if (HAS_GAP) begin
          state_d  = S_GAP;
          cfg_en_d = 2'b00;
          cnt_d    = GAP_LOAD;
        end else begin
          state_d   = S_LO;
          cfg_out_d = shadow_q[7:0];
          cfg_en_d  = 2'b01;
          cnt_d     = HOLD_LOAD;
        end
      end

      S_GAP: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d   = S_LO;
          cfg_out_d = shadow_q[7:0];
          cfg_en_d  = 2'b01;
          cnt_d     = HOLD_LOAD;
        end
      end

      S_LO: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d  = S_IDLE;
          cfg_en_d = 2'b00;
        end
      end

      default: begin
        state_d  = S_IDLE;
        cfg_en_d = 2'b00;
        cnt_d    = 8'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      shadow_q  <= SHADOW_RESET;
      lo_pend_q <= 1'b0;
      cfg_out_q <= 8'd0;
      cfg_en_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      lo_pend_q <= lo_pend_d;
      cfg_out_q <= cfg_out_d;
      cfg_en_q  <= cfg_en_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.cfg_out  = cfg_out_q;
  assign bus.cfg_en   = {6'b000000, cfg_en_q};

endmodule

// File: tb/tb_synth_cfg_writer.sv
// Directed bench for synth_cfg_writer: default-parameter instance with a voice model,
// plus a HOLD=3/GAP=0/no-skip instance for the long-strobe and forced-write cases.
module tb_synth_cfg_writer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] voice_cfg;

  always #5 clk = ~clk;

  synth_cfg_if bus_a ();
  synth_cfg_if bus_b ();

  synth_cfg_writer dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  synth_cfg_writer #(
    .HOLD_CYCLES    (3),
    .GAP_CYCLES     (0),
    .SKIP_UNCHANGED (1'b0)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  // Voice config register as the voice implements it, fed by dut_a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voice_cfg <= 16'h0638;
    end else begin
      if (bus_a.cfg_en[1]) voice_cfg[15:7] <= {1'b0, bus_a.cfg_out};
      if (bus_a.cfg_en[0]) voice_cfg[7:0]  <= bus_a.cfg_out;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [14:0] w);
    check("a_ready_before_send", 16'(bus_a.in_ready), 16'h1);
    bus_a.word_in  = w;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [14:0] w);
    check("b_ready_before_send", 16'(bus_b.in_ready), 16'h1);
    bus_b.word_in  = w;
    bus_b.in_valid = 1'b1;
    tick();
    bus_b.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] b_en_exp  [6];
    logic [7:0] b_out_exp [6];
    b_en_exp  = '{8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01};
    b_out_exp = '{8'h0C, 8'h0C, 8'h0C, 8'h38, 8'h38, 8'h38};

    rst_n          = 1'b0;
    bus_a.word_in  = '0;
    bus_a.in_valid = 1'b0;
    bus_b.word_in  = '0;
    bus_b.in_valid = 1'b0;

    // Reset state
    #22;
    check("rst_ready",   16'(bus_a.in_ready), 16'h0);
    check("rst_en",      16'(bus_a.cfg_en),   16'h00);
    check("rst_out",     16'(bus_a.cfg_out),  16'h00);
    check("rst_busy",    16'(bus_a.busy),     16'h0);
    check("rst_b_ready", 16'(bus_b.in_ready), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_ready",   16'(bus_a.in_ready), 16'h1);
    check("rel_b_ready", 16'(bus_b.in_ready), 16'h1);

    // Word equal to reset shadow: consumed with no strobes
    send_a(15'h0638);
    check("same_en",    16'(bus_a.cfg_en),   16'h00);
    check("same_ready", 16'(bus_a.in_ready), 16'h1);
    check("same_busy",  16'(bus_a.busy),     16'h0);

    // LO only
    send_a(15'h0639);
    check("lo_en_c1",    16'(bus_a.cfg_en),   16'h01);
    check("lo_out_c1",   16'(bus_a.cfg_out),  16'h39);
    check("lo_ready_c1", 16'(bus_a.in_ready), 16'h0);
    tick();
    check("lo_en_c2",    16'(bus_a.cfg_en),   16'h00);
    check("lo_ready_c2", 16'(bus_a.in_ready), 16'h1);
    check("lo_out_hold", 16'(bus_a.cfg_out),  16'h39);
    check("lo_voice",    voice_cfg,           16'h0639);

    // 0x0738 after 0x0639: HI byte changes to 0E and bits 6:0 change 39->38, so both writes
    send_a(15'h0738);
    check("hi_en_c1",  16'(bus_a.cfg_en),  16'h02);
    check("hi_out_c1", 16'(bus_a.cfg_out), 16'h0E);
    tick();
    check("hi_en_c2",  16'(bus_a.cfg_en),  16'h00);
    check("hi_out_c2", 16'(bus_a.cfg_out), 16'h0E);
    tick();
    check("hi_en_c3",  16'(bus_a.cfg_en),  16'h01);
    check("hi_out_c3", 16'(bus_a.cfg_out), 16'h38);
    tick();
    check("hi_ready_c4", 16'(bus_a.in_ready), 16'h1);
    check("hi_voice",    voice_cfg,           16'h0738);

    // HI only: 0x07B8 changes bit 7 alone
    send_a(15'h07B8);
    check("hionly_en_c1",  16'(bus_a.cfg_en),  16'h02);
    check("hionly_out_c1", 16'(bus_a.cfg_out), 16'h0F);
    tick();
    check("hionly_en_c2",    16'(bus_a.cfg_en),   16'h00);
    check("hionly_ready_c2", 16'(bus_a.in_ready), 16'h1);
    check("hionly_voice",    voice_cfg,           16'h07B8);

    // Back-to-back skipped words on consecutive edges
    bus_a.word_in  = 15'h07B8;
    bus_a.in_valid = 1'b1;
    tick();
    check("b2b_ready_1", 16'(bus_a.in_ready), 16'h1);
    check("b2b_en_1",    16'(bus_a.cfg_en),   16'h00);
    tick();
    bus_a.in_valid = 1'b0;
    check("b2b_ready_2", 16'(bus_a.in_ready), 16'h1);
    check("b2b_en_2",    16'(bus_a.cfg_en),   16'h00);

    // Full write 0x7FFF
    send_a(15'h7FFF);
    check("full_en_c1",  16'(bus_a.cfg_en),  16'h02);
    check("full_out_c1", 16'(bus_a.cfg_out), 16'hFF);
    tick();
    check("full_en_c2",    16'(bus_a.cfg_en),   16'h00);
    check("full_ready_c2", 16'(bus_a.in_ready), 16'h0);
    check("full_busy_c2",  16'(bus_a.busy),     16'h1);
    tick();
    check("full_en_c3",  16'(bus_a.cfg_en),  16'h01);
    check("full_out_c3", 16'(bus_a.cfg_out), 16'hFF);
    tick();
    check("full_ready_c4", 16'(bus_a.in_ready), 16'h1);
    check("full_en_c4",    16'(bus_a.cfg_en),   16'h00);
    check("full_voice",    voice_cfg,           16'h7FFF);

    // in_valid held across a sequence: next accept only once back in IDLE
    bus_a.word_in  = 15'h0000;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.word_in = 15'h7FFF;
    check("hold_en_c1",  16'(bus_a.cfg_en),  16'h02);
    check("hold_out_c1", 16'(bus_a.cfg_out), 16'h00);
    tick();
    check("hold_en_c2", 16'(bus_a.cfg_en), 16'h00);
    tick();
    check("hold_en_c3",  16'(bus_a.cfg_en),  16'h01);
    check("hold_out_c3", 16'(bus_a.cfg_out), 16'h00);
    tick();
    check("hold_ready_c4", 16'(bus_a.in_ready), 16'h1);
    check("hold_voice_c4", voice_cfg,           16'h0000);
    tick();
    bus_a.in_valid = 1'b0;
    check("hold_en_c5",  16'(bus_a.cfg_en),  16'h02);
    check("hold_out_c5", 16'(bus_a.cfg_out), 16'hFF);
    tick();
    tick();
    tick();
    check("hold_ready_c8", 16'(bus_a.in_ready), 16'h1);
    check("hold_voice_c8", voice_cfg,           16'h7FFF);

    // Reset during GAP
    send_a(15'h0000);
    check("gaprst_en_c1", 16'(bus_a.cfg_en), 16'h02);
    tick();
    check("gaprst_busy_c2", 16'(bus_a.busy), 16'h1);
    rst_n = 1'b0;
    #1;
    check("gaprst_en",    16'(bus_a.cfg_en),   16'h00);
    check("gaprst_out",   16'(bus_a.cfg_out),  16'h00);
    check("gaprst_busy",  16'(bus_a.busy),     16'h0);
    check("gaprst_ready", 16'(bus_a.in_ready), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_a(15'h0638);
    check("gaprst_same_en",    16'(bus_a.cfg_en),   16'h00);
    check("gaprst_same_ready", 16'(bus_a.in_ready), 16'h1);
    check("gaprst_voice",      voice_cfg,           16'h0638);

    // HOLD=3, GAP=0, no skipping: unchanged word is still written in full
    send_b(15'h0638);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b_en_c%0d", i + 1),    16'(bus_b.cfg_en),   16'(b_en_exp[i]));
      check($sformatf("b_out_c%0d", i + 1),   16'(bus_b.cfg_out),  16'(b_out_exp[i]));
      check($sformatf("b_ready_c%0d", i + 1), 16'(bus_b.in_ready), 16'h0);
      tick();
    end
    check("b_ready_c7", 16'(bus_b.in_ready), 16'h1);
    check("b_en_c7",    16'(bus_b.cfg_en),   16'h00);
    check("b_out_c7",   16'(bus_b.cfg_out),  16'h38);

    // Reset mid-strobe drops the enable immediately
    send_b(15'h0638);
    check("b_rst_en_before", 16'(bus_b.cfg_en), 16'h02);
    rst_n = 1'b0;
    #1;
    check("b_rst_en_after", 16'(bus_b.cfg_en), 16'h00);
    check("b_rst_busy",     16'(bus_b.busy),   16'h0);
    do_reset();
    check("b_rst_ready", 16'(bus_b.in_ready), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
